// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: alu_op codes, RV32I opcodes and operand selects.
// Also holds the funct3 -> arithmetic alu_op mapping shared by R-type and I-ALU decode.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SEL_A_RS1  = 2'd0,
    SEL_A_PC   = 2'd1,
    SEL_A_ZERO = 2'd2
  } sel_a_e;

  typedef enum logic {
    SEL_B_RS2 = 1'b0,
    SEL_B_IMM = 1'b1
  } sel_b_e;

  // allow_sub is clear for I-ALU, where funct3 000 is always ADDI.
  function automatic logic [3:0] arith_op(input logic [2:0] funct3,
                                          input logic       alt,
                                          input logic       allow_sub);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into alu_op, operand selects and instruction class flags.
// Unsupported encodings come out as ADD with illegal set; the top zeroes their operands.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o,
  output sel_a_e     sel_a_o,
  output sel_b_e     sel_b_o,
  output logic       is_branch_o,
  output logic       writes_rd_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o    = ALU_ADD;
    sel_a_o     = SEL_A_ZERO;
    sel_b_o     = SEL_B_RS2;
    is_branch_o = 1'b0;
    writes_rd_o = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OPC_R: begin
        alu_op_o    = arith_op(funct3_i, funct7_5_i, 1'b1);
        sel_a_o     = SEL_A_RS1;
        writes_rd_o = 1'b1;
      end
      OPC_I: begin
        alu_op_o    = arith_op(funct3_i, funct7_5_i, 1'b0);
        sel_a_o     = SEL_A_RS1;
        sel_b_o     = SEL_B_IMM;
        writes_rd_o = 1'b1;
      end
      OPC_LOAD: begin
        sel_a_o     = SEL_A_RS1;
        sel_b_o     = SEL_B_IMM;
        writes_rd_o = 1'b1;
      end
      OPC_STORE: begin
        sel_a_o = SEL_A_RS1;
        sel_b_o = SEL_B_IMM;
      end
      OPC_LUI: begin
        sel_b_o     = SEL_B_IMM;
        writes_rd_o = 1'b1;
      end
      OPC_AUIPC: begin
        sel_a_o     = SEL_A_PC;
        sel_b_o     = SEL_B_IMM;
        writes_rd_o = 1'b1;
      end
      OPC_BRANCH: begin
        sel_a_o     = SEL_A_RS1;
        is_branch_o = 1'b1;
        case (funct3_i)
          3'b000:  alu_op_o = ALU_BEQ;
          3'b001:  alu_op_o = ALU_BNE;
          3'b100:  alu_op_o = ALU_BLT;
          3'b101:  alu_op_o = ALU_BGE;
          default: begin
            // BLTU/BGEU and reserved funct3 have no alu_op code
            sel_a_o     = SEL_A_ZERO;
            is_branch_o = 1'b0;
            illegal_o   = 1'b1;
          end
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX and EX registers around an external combinational ALU, with valid/ready handshake.
// Define ALU_ISSUE_FWD_EN to forward ex_result into rs1/rs2-sourced operands.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] alu_data_one,
  output logic [XLEN-1:0] alu_data_two,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_result,
  output logic [4:0]      ex_rd,
  output logic            ex_branch_taken,
  output logic [XLEN-1:0] ex_branch_target,
  output logic            ex_illegal
);

  logic [3:0] dec_op;
  sel_a_e     dec_sel_a;
  sel_b_e     dec_sel_b;
  logic       dec_branch;
  logic       dec_writes_rd;
  logic       dec_illegal;

  alu_op_decode u_decode (
    .opcode_i    (in_opcode),
    .funct3_i    (in_funct3),
    .funct7_5_i  (in_funct7_5),
    .alu_op_o    (dec_op),
    .sel_a_o     (dec_sel_a),
    .sel_b_o     (dec_sel_b),
    .is_branch_o (dec_branch),
    .writes_rd_o (dec_writes_rd),
    .illegal_o   (dec_illegal)
  );

  logic            idex_valid_q;
  logic [3:0]      idex_op_q;
  sel_a_e          idex_sel_a_q;
  sel_b_e          idex_sel_b_q;
  logic            idex_branch_q;
  logic            idex_illegal_q;
  logic [4:0]      idex_rd_q;
  logic [XLEN-1:0] idex_rs1_q;
  logic [XLEN-1:0] idex_rs2_q;
  logic [XLEN-1:0] idex_imm_q;
  logic [XLEN-1:0] idex_pc_q;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_result_q;
  logic [4:0]      ex_rd_q;
  logic            ex_taken_q;
  logic [XLEN-1:0] ex_target_q;
  logic            ex_illegal_q;

  logic            accept;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign in_ready = !stall || !idex_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign rd_d     = (dec_writes_rd && !dec_illegal) ? in_rd : 5'd0;

`ifdef ALU_ISSUE_FWD_EN
  logic [4:0] idex_rs1_addr_q;
  logic [4:0] idex_rs2_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_rs1_addr_q <= '0;
      idex_rs2_addr_q <= '0;
    end else if (accept) begin
      idex_rs1_addr_q <= in_rs1_addr;
      idex_rs2_addr_q <= in_rs2_addr;
    end
  end

  // ex_rd is already 0 for branch/store/illegal, so those never forward
  always_comb begin
    rs1_val = idex_rs1_q;
    rs2_val = idex_rs2_q;
    if (ex_valid_q && (ex_rd_q != 5'd0) && (ex_rd_q == idex_rs1_addr_q)) rs1_val = ex_result_q;
    if (ex_valid_q && (ex_rd_q != 5'd0) && (ex_rd_q == idex_rs2_addr_q)) rs2_val = ex_result_q;
  end
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{in_rs1_addr, in_rs2_addr};

  always_comb begin
    rs1_val = idex_rs1_q;
    rs2_val = idex_rs2_q;
  end
`endif

  always_comb begin
    op_a = '0;
    case (idex_sel_a_q)
      SEL_A_RS1: op_a = rs1_val;
      SEL_A_PC:  op_a = idex_pc_q;
      default:   op_a = '0;
    endcase
    op_b = (idex_sel_b_q == SEL_B_IMM) ? idex_imm_q : rs2_val;
    if (!idex_valid_q || idex_illegal_q) begin
      op_a = '0;
      op_b = '0;
    end
  end

  assign alu_data_one = op_a;
  assign alu_data_two = op_b;
  assign alu_op       = idex_valid_q ? idex_op_q : ALU_ADD;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_q   <= 1'b0;
      idex_op_q      <= ALU_ADD;
      idex_sel_a_q   <= SEL_A_ZERO;
      idex_sel_b_q   <= SEL_B_RS2;
      idex_branch_q  <= 1'b0;
      idex_illegal_q <= 1'b0;
      idex_rd_q      <= '0;
      idex_rs1_q     <= '0;
      idex_rs2_q     <= '0;
      idex_imm_q     <= '0;
      idex_pc_q      <= '0;
    end else begin
      if (flush) begin
        idex_valid_q <= 1'b0;
      end else if (in_ready) begin
        idex_valid_q <= in_valid;
      end
      if (accept) begin
        idex_op_q      <= dec_op;
        idex_sel_a_q   <= dec_sel_a;
        idex_sel_b_q   <= dec_sel_b;
        idex_branch_q  <= dec_branch;
        idex_illegal_q <= dec_illegal;
        idex_rd_q      <= rd_d;
        idex_rs1_q     <= in_rs1_data;
        idex_rs2_q     <= in_rs2_data;
        idex_imm_q     <= in_imm;
        idex_pc_q      <= in_pc;
      end
    end
  end

  // A slot being flushed this edge moves into EX as a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_result_q  <= '0;
      ex_rd_q      <= '0;
      ex_taken_q   <= 1'b0;
      ex_target_q  <= '0;
      ex_illegal_q <= 1'b0;
    end else if (!stall) begin
      if (idex_valid_q && !flush) begin
        ex_valid_q   <= 1'b1;
        ex_result_q  <= alu_result;
        ex_rd_q      <= idex_rd_q;
        ex_taken_q   <= idex_branch_q && alu_zero;
        ex_target_q  <= idex_branch_q ? (idex_pc_q + idex_imm_q) : '0;
        ex_illegal_q <= idex_illegal_q;
      end else begin
        ex_valid_q   <= 1'b0;
        ex_result_q  <= '0;
        ex_rd_q      <= '0;
        ex_taken_q   <= 1'b0;
        ex_target_q  <= '0;
        ex_illegal_q <= 1'b0;
      end
    end
  end

  assign ex_valid         = ex_valid_q;
  assign ex_result        = ex_result_q;
  assign ex_rd            = ex_rd_q;
  assign ex_branch_taken  = ex_taken_q;
  assign ex_branch_target = ex_target_q;
  assign ex_illegal       = ex_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a behavioural ALU drives alu_result/alu_zero,
// expected EX contents are queued at accept and compared when they reach the EX register.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        stall, flush;
  logic [31:0] alu_data_one, alu_data_two, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        ex_valid, ex_branch_taken, ex_illegal;
  logic [31:0] ex_result, ex_branch_target;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .alu_data_one(alu_data_one), .alu_data_two(alu_data_two), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic        want_res_en;
    logic [31:0] want_res;
    logic        want_tk_en;
    logic        want_tk;
  } ins_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res, target;
    logic [4:0]  rd;
    logic        br, taken, ill;
    logic        want_res_en;
    logic [31:0] want_res;
    logic        want_tk_en;
    logic        want_tk;
  } exp_t;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << b[4:0];
      4'b0011: return {31'd0, $signed(a) < $signed(b)};
      4'b0100: return {31'd0, a < b};
      4'b0101: return a ^ b;
      4'b0110: return $unsigned($signed(a) >>> b[4:0]);
      4'b0111: return a >> b[4:0];
      4'b1000: return a | b;
      4'b1001: return a & b;
      4'b1010, 4'b1011, 4'b1100, 4'b1101: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic alu_zf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b1010: return a == b;
      4'b1011: return a != b;
      4'b1100: return $signed(a) < $signed(b);
      4'b1101: return $signed(a) >= $signed(b);
      default: return alu_fn(op, a, b) == 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_data_one, alu_data_two);
  assign alu_zero   = alu_zf(alu_op, alu_data_one, alu_data_two);

  function automatic logic [3:0] ref_arith(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0010;
      3'b010:  return 4'b0011;
      3'b011:  return 4'b0100;
      3'b100:  return 4'b0101;
      3'b101:  return f7 ? 4'b0110 : 4'b0111;
      3'b110:  return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  // fv/frd/fres describe the EX entry that sits beside this instruction while it is in ID/EX
  function automatic exp_t ref_model(input ins_t i, input logic fv, input logic [4:0] frd, input logic [31:0] fres);
    exp_t e;
    logic [1:0]  sa;
    logic        sb, wr;
    logic [31:0] v1, v2;
    e.op = 4'b0000; sa = 2; sb = 0; wr = 0; e.br = 0; e.ill = 0;
    case (i.opc)
      7'b0110011: begin e.op = ref_arith(i.f3, i.f7, 1'b1); sa = 0; wr = 1; end
      7'b0010011: begin e.op = ref_arith(i.f3, i.f7, 1'b0); sa = 0; sb = 1; wr = 1; end
      7'b0000011: begin sa = 0; sb = 1; wr = 1; end
      7'b0100011: begin sa = 0; sb = 1; end
      7'b0110111: begin sa = 2; sb = 1; wr = 1; end
      7'b0010111: begin sa = 1; sb = 1; wr = 1; end
      7'b1100011: begin
        sa = 0; e.br = 1;
        case (i.f3)
          3'b000: e.op = 4'b1010;
          3'b001: e.op = 4'b1011;
          3'b100: e.op = 4'b1100;
          3'b101: e.op = 4'b1101;
          default: begin e.br = 0; e.ill = 1; end
        endcase
      end
      default: e.ill = 1;
    endcase
    v1 = i.rs1d; v2 = i.rs2d;
`ifdef ALU_ISSUE_FWD_EN
    if (fv && frd != 5'd0 && frd == i.rs1a) v1 = fres;
    if (fv && frd != 5'd0 && frd == i.rs2a) v2 = fres;
`else
    if (fv && frd == 5'd31 && fres == 32'hDEAD_BEEF) v1 = i.rs1d;
`endif
    e.a = (sa == 0) ? v1 : (sa == 1) ? i.pc : 32'd0;
    e.b = sb ? i.imm : v2;
    if (e.ill) begin e.a = 0; e.b = 0; end
    e.res    = alu_fn(e.op, e.a, e.b);
    e.taken  = e.br && alu_zf(e.op, e.a, e.b);
    e.target = i.pc + i.imm;
    e.rd     = (wr && !e.ill) ? i.rd : 5'd0;
    e.want_res_en = i.want_res_en; e.want_res = i.want_res;
    e.want_tk_en  = i.want_tk_en;  e.want_tk  = i.want_tk;
    return e;
  endfunction

  function automatic ins_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rd,
                              input logic [31:0] rs1d, input logic [31:0] rs2d,
                              input logic [31:0] imm, input logic [31:0] pc);
    ins_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1a = rs1a; i.rs2a = rs2a; i.rd = rd;
    i.rs1d = rs1d; i.rs2d = rs2d; i.imm = imm; i.pc = pc;
    i.want_res_en = 0; i.want_res = 0; i.want_tk_en = 0; i.want_tk = 0;
    return i;
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%08h want=0x%08h t=%0t", tag, got, want, $time);
    end
  endtask

  exp_t q[$];
  exp_t tb_ex;
  logic tb_ex_v   = 1'b0;
  logic tb_idex_v = 1'b0;
  ins_t cur, ins_s;
  logic rst_s = 1'b1, adv_s = 1'b0, fl_s = 1'b0, acc_s = 1'b0;

  always @(negedge clk) begin
    rst_s = rst;
    adv_s = !stall;
    fl_s  = flush;
    acc_s = in_valid && (!stall || !tb_idex_v) && !flush;
    ins_s = cur;
    if (!rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!stall || !tb_idex_v)});
      if (tb_idex_v) begin
        chk("alu_op", {28'd0, alu_op}, {28'd0, q[0].op});
        chk("alu_one", alu_data_one, q[0].a);
        chk("alu_two", alu_data_two, q[0].b);
      end else begin
        chk("idle_op", {28'd0, alu_op}, 32'd0);
        chk("idle_one", alu_data_one, 32'd0);
        chk("idle_two", alu_data_two, 32'd0);
      end
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, tb_ex_v});
      if (tb_ex_v) begin
        chk("ex_result", ex_result, tb_ex.res);
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, tb_ex.rd});
        chk("ex_taken", {31'd0, ex_branch_taken}, {31'd0, tb_ex.taken});
        chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, tb_ex.ill});
        if (tb_ex.br) chk("ex_target", ex_branch_target, tb_ex.target);
      end else begin
        chk("bub_rd", {27'd0, ex_rd}, 32'd0);
        chk("bub_taken", {31'd0, ex_branch_taken}, 32'd0);
        chk("bub_illegal", {31'd0, ex_illegal}, 32'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      q.delete();
      tb_idex_v = 0;
      tb_ex_v   = 0;
    end else begin
      if (adv_s) begin
        if (tb_idex_v && !fl_s) begin
          tb_ex   = q[0];
          tb_ex_v = 1;
          if (tb_ex.want_res_en) chk("want_res", ex_result, tb_ex.want_res);
          if (tb_ex.want_tk_en)  chk("want_taken", {31'd0, ex_branch_taken}, {31'd0, tb_ex.want_tk});
        end else begin
          tb_ex_v = 0;
        end
      end
      if (tb_idex_v && (adv_s || fl_s)) begin
        q.delete(0);
        tb_idex_v = 0;
      end
      if (acc_s) begin
        q.push_back(ref_model(ins_s, tb_ex_v, tb_ex.rd, tb_ex.res));
        tb_idex_v = 1;
      end
    end
  end

  task automatic step(input ins_t i, input logic v, input logic st, input logic fl);
    cur         = i;
    in_opcode   = i.opc;  in_funct3   = i.f3;   in_funct7_5 = i.f7;
    in_rs1_addr = i.rs1a; in_rs2_addr = i.rs2a; in_rd       = i.rd;
    in_rs1_data = i.rs1d; in_rs2_data = i.rs2d; in_imm      = i.imm; in_pc = i.pc;
    in_valid = v; stall = st; flush = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  ins_t nop_i, a_i, b_i, c_i;
  logic [6:0] opcs [9];

  initial begin
    nop_i = mk(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_result", ex_result, 32'd0);
    chk("rst_ex_target", ex_branch_target, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_one", alu_data_one, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step(nop_i, 0, 0, 0);

    // ADD R-type 10 + 5 -> x3
    a_i = mk(7'b0110011, 3'b000, 0, 1, 2, 3, 32'd10, 32'd5, 32'd0, 32'h40);
    a_i.want_res_en = 1; a_i.want_res = 32'd15;
    step(a_i, 1, 0, 0);
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);

    // SRAI 0xFFFFFFF0 >>> 2
    a_i = mk(7'b0010011, 3'b101, 1, 4, 0, 6, 32'hFFFF_FFF0, 32'd0, 32'd2, 32'h44);
    a_i.want_res_en = 1; a_i.want_res = 32'hFFFF_FFFC;
    step(a_i, 1, 0, 0);
    // BEQ taken, then BNE not taken, back to back
    b_i = mk(7'b1100011, 3'b000, 0, 1, 2, 7, 32'd5, 32'd5, 32'h20, 32'h100);
    b_i.want_tk_en = 1; b_i.want_tk = 1;
    step(b_i, 1, 0, 0);
    c_i = b_i; c_i.f3 = 3'b001; c_i.want_tk = 0;
    step(c_i, 1, 0, 0);
    step(nop_i, 0, 0, 0);
    chk("bne_target", ex_branch_target, 32'h120);
    chk("bne_rd", {27'd0, ex_rd}, 32'd0);
    step(nop_i, 0, 0, 0);

    // stall for 3 cycles with ID/EX full and a new instruction waiting
    a_i = mk(7'b0110011, 3'b110, 0, 1, 2, 9, 32'hF0F0_0000, 32'h0000_0F0F, 0, 0);
    a_i.want_res_en = 1; a_i.want_res = 32'hF0F0_0F0F;
    b_i = mk(7'b0110011, 3'b000, 1, 1, 2, 10, 32'd100, 32'd1, 0, 0);
    b_i.want_res_en = 1; b_i.want_res = 32'd99;
    step(a_i, 1, 0, 0);
    step(b_i, 1, 1, 0);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    step(b_i, 1, 1, 0);
    step(b_i, 1, 1, 0);
    step(b_i, 1, 0, 0);
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);

    // flush with a full ID/EX, stall and a fresh input all at once
    step(a_i, 1, 0, 0);
    step(b_i, 1, 1, 1);
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_alu_op", {28'd0, alu_op}, 32'd0);
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);

    // JAL is illegal: rd forced to 0, operands 0
    a_i = mk(7'b1101111, 3'b000, 0, 1, 2, 5, 32'h1234, 32'h5678, 32'h8, 32'h200);
    a_i.want_res_en = 1; a_i.want_res = 32'd0;
    step(a_i, 1, 0, 0);
    step(nop_i, 0, 0, 0);
    chk("jal_illegal", {31'd0, ex_illegal}, 32'd1);
    chk("jal_rd", {27'd0, ex_rd}, 32'd0);
    step(nop_i, 0, 0, 0);

    // RAW distance 1: ADD x1 = 3 + 4, then ADDI x2 = x1 + 1 with stale x1 = 0
    a_i = mk(7'b0110011, 3'b000, 0, 5, 6, 1, 32'd3, 32'd4, 0, 0);
    a_i.want_res_en = 1; a_i.want_res = 32'd7;
    b_i = mk(7'b0010011, 3'b000, 0, 1, 0, 2, 32'd0, 32'd0, 32'd1, 0);
    b_i.want_res_en = 1;
`ifdef ALU_ISSUE_FWD_EN
    b_i.want_res = 32'd8;
`else
    b_i.want_res = 32'd1;
`endif
    step(a_i, 1, 0, 0);
    step(b_i, 1, 0, 0);
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);

    // random traffic with stalls and flushes
    opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
    opcs[3] = 7'b0100011; opcs[4] = 7'b0110111; opcs[5] = 7'b0010111;
    opcs[6] = 7'b1100011; opcs[7] = 7'b1101111; opcs[8] = 7'b1100111;
    for (int n = 0; n < 80; n++) begin
      a_i = mk(opcs[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom, (n % 3 == 0) ? 32'd77 : $urandom, 32'($urandom_range(0, 40)), $urandom);
      step(a_i, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);
    step(nop_i, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream (driving) end of the ALU operand/opcode interface.
- Decodes RV32I instruction fields into the 4-bit alu_op, selects operands, and registers them in an ID/EX register that drives the combinational ALU.
- Captures alu_result/zero into an EX result register, resolving branches there.
- Sits between the register-file read stage and memory/writeback.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  stage can accept this cycle
- in_opcode  in  7  instruction[6:0]
- in_funct3  in  3  instruction[14:12]
- in_funct7_5  in  1  instruction[30]
- in_rs1_addr, in_rs2_addr, in_rd  in  5 each  register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction PC
- stall  in  1  downstream cannot accept; hold both registers
- flush  in  1  squash ID/EX contents and this cycle's input
- alu_data_one, alu_data_two  out  XLEN  ALU operands
- alu_op  out  4  ALU opcode
- alu_result  in  XLEN  ALU result
- alu_zero  in  1  ALU zero flag
- ex_valid  out  1  result register holds an instruction
- ex_result  out  XLEN  registered ALU result
- ex_rd  out  5  destination index, forced to 0 for branch/store/illegal
- ex_branch_taken  out  1  resolved branch taken
- ex_branch_target  out  XLEN  pc + imm of the branch
- ex_illegal  out  1  unsupported encoding

Behaviour:
- Reset clears both valids; all ex_* outputs are 0; alu_op = 0000; operands = 0.
- alu_op codes:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRA 0110, SRL 0111, OR 1000, AND 1001.
  - Branch codes BEQ 1010, BNE 1011, BLT 1100, BGE 1101. For these, the ALU asserts zero when the branch condition is true.
- Decode rules:
  - R-type 0110011: uses funct3/funct7_5. SUB and SRA are selected when funct7_5=1.
  - I-ALU 0010011: same mapping, except funct3 000 is always ADD. SRAI is selected when funct7_5=1.
  - Load 0000011 and store 0100011: ADD rs1+imm.
  - LUI 0110111: operands 0 and imm, ADD.
  - AUIPC 0010111: operands pc and imm, ADD.
  - Branch 1100011: funct3 000/001/100/101 map to 1010/1011/1100/1101. Operands are rs1, rs2.
  - Everything else, including BLTU/BGEU, JAL and JALR, is illegal: ADD with operands 0/0, ex_illegal=1, ex_rd=0.
- Handshake:
  - in_ready = !stall || !idex_valid.
  - Transfer occurs when in_valid && in_ready && !flush.
- Latency:
  - Instruction accepted at edge N drives the ALU after edge N.
  - ex_* outputs are valid after edge N+1.
  - Throughput is one instruction per cycle.
- Stall: ID/EX and EX registers hold their values; ALU inputs are stable.
- Flush:
  - Next edge clears idex_valid; EX captures valid=0 from the squashed slot.
  - Flush has priority over stall and over a simultaneous input.
  - An EX entry already present is unaffected.
- Branch resolution: ex_branch_taken = branch && alu_zero, captured at the EX edge. It is 0 whenever ex_valid=0.
- Arithmetic: branch target = pc + imm mod 2^XLEN; wrap-around is ignored.
- Invalid slots:
  - Invalid ID/EX drives alu_op 0000 with zero operands.
  - Invalid EX forces ex_branch_taken, ex_illegal and ex_rd to 0.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Enabled: an ALU operand sourced from rs1 or rs2 takes ex_result instead of register data when ex_valid, ex_rd != 0 and ex_rd equals the ID/EX rs index. This removes the distance-1 RAW hazard. Imm/pc/zero operands are never forwarded.
- Disabled: operands are always the captured register data, and the rs address ports are unused.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 14 alu_op codes;
  - opcode constants (R, I, LOAD, STORE, LUI, AUIPC, BRANCH);
  - operand-select encodings (RS1/PC/ZERO, RS2/IMM).
- Combinational sub-module alu_op_decode maps opcode/funct3/funct7_5 to alu_op, operand selects, is_branch, writes_rd and illegal.
- The top level holds the registers, handshake and forwarding.

Test Plan:
- ADD R-type, rs1=10, rs2=5, rd=3 -> alu_op 0000 one cycle after accept; next cycle ex_result=15, ex_rd=3, ex_valid=1.
- SRAI rs1=0xFFFFFFF0, imm=2, funct7_5=1 -> alu_op 0110; ex_result=0xFFFFFFFC.
- BEQ rs1=rs2=5, pc=0x100, imm=0x20 -> alu_op 1010; ex_branch_taken=1, target=0x120, ex_rd=0. BNE with the same operands -> taken=0.
- stall held 3 cycles with in_valid=1 and ID/EX full -> in_ready=0, ALU inputs and ex_* frozen; the instruction completes once after release with no duplicate.
- flush coincident with in_valid and stall -> both slots squashed, ex_valid=0 next edge; opcode 1101111 (JAL) -> ex_illegal=1, ex_rd=0.
- ALU_ISSUE_FWD_EN: ADD x1=7 followed by ADDI x2=x1+1 with stale x1=0 -> ex_result 8 (without the macro: 1).
